// File: rtl/plab4_net_ter_domain_rx_pkg.sv
// Shared constants for the ring terminal domain adapters.
// Holds the domain tag encoding and the network message width helper.
package plab4_net_ter_domain_rx_pkg;

  localparam logic DOM_D1 = 1'b0;
  localparam logic DOM_D2 = 1'b1;

  // Message layout is {dest, src, opaque, payload}, dest at the MSB.
  function automatic int net_msg_nbits(
    input int p,
    input int o,
    input int s
  );
    return p + o + 2 * s;
  endfunction

endpackage

// File: rtl/plab4_net_ter_rx_queue.sv
// Circular FIFO for one domain of the terminal receive adapter.
// Ports: enq_val/enq_msg in, full out; deq_val/deq_msg out, deq_rdy in.
module plab4_net_ter_rx_queue #(
  parameter int p_msg_nbits   = 41,
  parameter int p_num_entries = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   full,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg
);

  localparam int AW = $clog2(p_num_entries);
  localparam int CW = AW + 1;

  logic [p_msg_nbits-1:0] mem [p_num_entries];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   enq;
  logic                   deq;

  assign full    = (count == CW'(p_num_entries));
  assign deq_val = (count != '0);
  assign deq_msg = mem[rd_ptr];

  // Full blocks enqueue even when a dequeue happens this cycle.
  assign enq = enq_val && !full;
  assign deq = deq_val && deq_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (!enq && deq) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/plab4_net_ter_domain_rx.sv
// Ring terminal receive adapter: steers ejected messages into two
// per-domain FIFOs and counts misrouted drops per domain.
// Ports: in_val/in_rdy/in_msg/in_domain from the router terminal;
// out_val/rdy/msg_d0 and _d1 to the domain consumers;
// drop_cnt_d0/_d1 saturating misroute counters.
// Macro PLAB4_NET_TER_DOMAIN_RX_BYPASS_EN enables zero-latency bypass
// into an empty buffer whose consumer is ready.
module plab4_net_ter_domain_rx
  import plab4_net_ter_domain_rx_pkg::*;
#(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_router_id     = 0,
  parameter int p_num_entries   = 4,
  parameter int p_errcnt_nbits  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_val,
  output logic in_rdy,
  input  logic [net_msg_nbits(p_payload_nbits, p_opaque_nbits,
                              p_srcdest_nbits)-1:0] in_msg,
  input  logic in_domain,
  output logic out_val_d0,
  input  logic out_rdy_d0,
  output logic [net_msg_nbits(p_payload_nbits, p_opaque_nbits,
                              p_srcdest_nbits)-1:0] out_msg_d0,
  output logic out_val_d1,
  input  logic out_rdy_d1,
  output logic [net_msg_nbits(p_payload_nbits, p_opaque_nbits,
                              p_srcdest_nbits)-1:0] out_msg_d1,
  output logic [p_errcnt_nbits-1:0] drop_cnt_d0,
  output logic [p_errcnt_nbits-1:0] drop_cnt_d1
);

  localparam int M = net_msg_nbits(p_payload_nbits, p_opaque_nbits,
                                   p_srcdest_nbits);
  localparam int S = p_srcdest_nbits;
  localparam int E = p_errcnt_nbits;

  logic         full0, full1;
  logic         qval0, qval1;
  logic [M-1:0] qmsg0, qmsg1;
  logic         dest_ok, acc, sel0, sel1;
  logic         byp0, byp1, enq0, enq1, drop0, drop1;

  assign dest_ok = (in_msg[M-1 -: S] == S'(p_router_id));
  assign sel0    = (in_domain == DOM_D1);
  assign sel1    = (in_domain == DOM_D2);

  // Only the selected domain's full flag gates the router.
  assign in_rdy = sel1 ? !full1 : !full0;
  assign acc    = in_val && in_rdy;

`ifdef PLAB4_NET_TER_DOMAIN_RX_BYPASS_EN
  assign byp0 = acc && sel0 && dest_ok && !qval0 && out_rdy_d0;
  assign byp1 = acc && sel1 && dest_ok && !qval1 && out_rdy_d1;
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  assign enq0  = acc && sel0 && dest_ok && !byp0;
  assign enq1  = acc && sel1 && dest_ok && !byp1;
  assign drop0 = acc && sel0 && !dest_ok;
  assign drop1 = acc && sel1 && !dest_ok;

  plab4_net_ter_rx_queue #(
    .p_msg_nbits   (M),
    .p_num_entries (p_num_entries)
  ) q_d0 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq0),
    .enq_msg (in_msg),
    .full    (full0),
    .deq_val (qval0),
    .deq_rdy (out_rdy_d0),
    .deq_msg (qmsg0)
  );

  plab4_net_ter_rx_queue #(
    .p_msg_nbits   (M),
    .p_num_entries (p_num_entries)
  ) q_d1 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq1),
    .enq_msg (in_msg),
    .full    (full1),
    .deq_val (qval1),
    .deq_rdy (out_rdy_d1),
    .deq_msg (qmsg1)
  );

  // Bypass only fires on an empty queue, so the two sources never collide.
  assign out_val_d0 = qval0 || byp0;
  assign out_val_d1 = qval1 || byp1;
  assign out_msg_d0 = qval0 ? qmsg0 : in_msg;
  assign out_msg_d1 = qval1 ? qmsg1 : in_msg;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_d0 <= '0;
      drop_cnt_d1 <= '0;
    end else begin
      if (drop0 && (drop_cnt_d0 != '1))
        drop_cnt_d0 <= drop_cnt_d0 + E'(1);
      if (drop1 && (drop_cnt_d1 != '1))
        drop_cnt_d1 <= drop_cnt_d1 + E'(1);
    end
  end

endmodule
